keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   Input-side scanner for the calculator's 4x4 key matrix; the counterpart of the display scan driver.
//   Drives rows active-low one at a time and samples the columns (pull-ups, active-low) through a 2-flop
//   synchronizer. Debounces press and release, then emits one raw key code per press to the calculator core.
// PARAMETERS
//   DEBOUNCE  20  clk_1khz cycles a pattern must stay stable to accept a press or a release (1..255)
//   SETTLE    3   cycles each row is driven before its columns are sampled (>=3; covers 2-flop sync)
// PORTS
//   clk_1khz   in   1  sole clock, 1 kHz tick domain
//   rst        in   1  synchronous, active-high reset
//   col_in     in   4  raw column lines, active-low, asynchronous to clk_1khz
//   row_out    out  4  row drive, active-low, exactly one bit low at all times
//   key_code   out  4  {row[1:0], col[1:0]} of the accepted key; held until the next accepted press
//   key_valid  out  1  one-cycle pulse when key_code updates
//   key_held   out  1  high from the key_valid cycle until release debounce completes
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): row_out=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN,
//     row ptr=0, dwell/debounce counters=0, synchronizer flops=4'b1111. Reset mid-debounce aborts silently.
//   col_s = col_in after 2 flops; "pressed" means col_s != 4'b1111.
//   SCAN: row ptr r held SETTLE cycles; on the last dwell cycle sample col_s:
//     - all high -> r advances (3 wraps to 0), dwell restarts.
//     - any low  -> latch r and col = lowest-index low bit (priority col0>col1>...); lat_pat=col_s;
//       go DEBOUNCE with cnt=0; row_out stays on r.
//   DEBOUNCE: each cycle, col_s==lat_pat -> cnt++; else -> back to SCAN, same r, dwell restarts, no output.
//     When cnt reaches DEBOUNCE-1 with a match: key_code<={r,col}, key_valid=1 for that cycle only,
//     key_held<=1, go PRESSED.
//   PRESSED: row held. col_s bit for latched col high -> go RELEASE with cnt=0. Extra keys ignored.
//   RELEASE: latched col bit stays high -> cnt++; goes low -> back to PRESSED (bounce, no new key_valid).
//     At cnt == DEBOUNCE-1 with bit high: key_held<=0, go SCAN, r advances (wrap), dwell restarts.
//   Latency: physical press to key_valid = <=4*SETTLE (scan) + 2 (sync) + DEBOUNCE cycles.
//   Bounded rates: at most one key_valid per press/release cycle; min gap between pulses is 2*DEBOUNCE.
//   Counters saturate-free by construction: 8-bit cnt, compare to DEBOUNCE-1 only.
//   Outputs registered; row_out derived from registered r (one-hot-low decode of r).
// STRUCTURE
//   keypad_pkg: state encoding (SCAN=2'd0, DEBOUNCE=2'd1, PRESSED=2'd2, RELEASE=2'd3),
//     ROWS=4, COLS=4, KEY_NONE=4'hF constant, and the key_code -> calculator symbol table (digits 0-9,
//     + - * / = C) consumed downstream, not by this block.
//   Sub-module kp_sync: 4-bit 2-flop synchronizer with reset value 4'b1111. Everything else flat.
// TESTING
//   (bench uses DEBOUNCE=4, SETTLE=3; matrix model pulls col low when its row is driven low and key closed)
//   1 Reset: rst high 2 cycles -> row_out=1110, key_valid=0, key_held=0, key_code=0; release -> rows
//     rotate 1110,1101,1011,0111,1110 every 3 cycles.
//   2 Clean press row2/col1 held 30 cycles -> exactly one key_valid, key_code=4'b1001, key_held=1,
//     row_out frozen at 1011; release -> key_held drops 4 cycles after col1 stable high, scan resumes at row3.
//   3 Bounce: row0/col3 toggled every 2 cycles for 10 cycles then stable -> no pulse during bounce,
//     single key_valid with key_code=4'h3 after 4 stable cycles.
//   4 Release bounce: while held, col opens 2 cycles and recloses, then opens for good -> no second
//     key_valid; key_held falls only after the final 4 stable-high cycles.
//   5 Two keys same row (row1 col0+col2) -> key_code=4'h4; second key on another row during PRESSED -> ignored.
//   6 rst asserted during DEBOUNCE -> no key_valid, outputs at reset values next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 calculator keypad scanner: state encoding,
// matrix geometry and the key_code to calculator symbol map used downstream.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [3:0] KEY_NONE = 4'hF;

  // Lowest-index active-low column wins when several keys share a row.
  function automatic logic [1:0] first_low(input logic [3:0] pat);
    logic [1:0] idx;
    if (!pat[0])      idx = 2'd0;
    else if (!pat[1]) idx = 2'd1;
    else if (!pat[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  // ASCII symbol printed on each key cap; code is {row, col}.
  function automatic logic [7:0] key_symbol(input logic [3:0] code);
    logic [7:0] sym;
    case (code)
      4'h0: sym = "1";
      4'h1: sym = "2";
      4'h2: sym = "3";
      4'h3: sym = "+";
      4'h4: sym = "4";
      4'h5: sym = "5";
      4'h6: sym = "6";
      4'h7: sym = "-";
      4'h8: sym = "7";
      4'h9: sym = "8";
      4'hA: sym = "9";
      4'hB: sym = "*";
      4'hC: sym = "C";
      4'hD: sym = "0";
      4'hE: sym = "=";
      default: sym = "/";
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the asynchronous column lines; resets to the
// idle (all released, pulled-up) pattern.
module kp_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks an active-low row, samples synchronized columns,
// debounces press and release and emits one key_code/key_valid per press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 20,
  parameter int SETTLE   = 3
) (
  input  logic            clk_1khz,
  input  logic            rst,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam logic [7:0] DWELL_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE - 1);

  logic [3:0] col_s;
  state_t     state, state_nx;
  logic [1:0] row, row_nx;
  logic [1:0] col, col_nx;
  logic [7:0] dwell, dwell_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] lat_pat, lat_pat_nx;
  logic [3:0] code_nx;
  logic       valid_nx, held_nx;

  kp_sync u_sync (
    .clk (clk_1khz),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  assign row_out = ~(4'd1 << row);

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state     <= ST_SCAN;
      row       <= 2'd0;
      col       <= 2'd0;
      dwell     <= 8'd0;
      cnt       <= 8'd0;
      lat_pat   <= 4'b1111;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      row       <= row_nx;
      col       <= col_nx;
      dwell     <= dwell_nx;
      cnt       <= cnt_nx;
      lat_pat   <= lat_pat_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

  // The row stays frozen from the first low sample until release completes,
  // so other rows are invisible while a key is being debounced or held.
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    col_nx     = col;
    dwell_nx   = dwell;
    cnt_nx     = cnt;
    lat_pat_nx = lat_pat;
    code_nx    = key_code;
    valid_nx   = 1'b0;
    held_nx    = key_held;

    case (state)
      ST_SCAN: begin
        if (dwell == DWELL_LAST) begin
          if (col_s == 4'b1111) begin
            row_nx   = row + 2'd1;
            dwell_nx = 8'd0;
          end else begin
            col_nx     = first_low(col_s);
            lat_pat_nx = col_s;
            cnt_nx     = 8'd0;
            state_nx   = ST_DEBOUNCE;
          end
        end else begin
          dwell_nx = dwell + 8'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (col_s == lat_pat) begin
          if (cnt == CNT_LAST) begin
            code_nx  = {row, col};
            valid_nx = 1'b1;
            held_nx  = 1'b1;
            state_nx = ST_PRESSED;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end else begin
          dwell_nx = 8'd0;
          state_nx = ST_SCAN;
        end
      end
      ST_PRESSED: begin
        if (col_s[col]) begin
          cnt_nx   = 8'd0;
          state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (col_s[col]) begin
          if (cnt == CNT_LAST) begin
            held_nx  = 1'b0;
            row_nx   = row + 2'd1;
            dwell_nx = 8'd0;
            state_nx = ST_SCAN;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end else begin
          state_nx = ST_PRESSED;
        end
      end
      default: state_nx = ST_SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a 4x4 switch-matrix model driving the
// column lines from the DUT's row drive (DEBOUNCE=4, SETTLE=3).
module tb_keypad_scan;

  logic       clk_1khz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  keypad_scan #(.DEBOUNCE(4), .SETTLE(3)) dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk_1khz = ~clk_1khz;

  // A closed key shorts its column to its row only while that row is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      if (!row_out[rr]) col_in = col_in & ~keys[rr];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_1khz);
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int p0 = pulses;
    int n = 0;
    while (pulses == p0 && n < max_cycles) begin
      step();
      n++;
    end
    check_output(tag, 32'(pulses != p0), 32'd1);
  endtask

  task automatic wait_release(input string tag, input int max_cycles);
    int n = 0;
    while (key_held === 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check_output(tag, 32'(key_held), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : apply_stimulus
    int p0;
    bit frozen;

    // 1: reset values, then free-running row rotation every 3 cycles
    rst = 1'b1;
    steps(2);
    check_output("rst_row", 32'(row_out), 32'h0000000E);
    check_output("rst_valid", 32'(key_valid), 32'd0);
    check_output("rst_held", 32'(key_held), 32'd0);
    check_output("rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_output($sformatf("rotate_%0d", k), 32'(row_out),
                   32'(~(4'd1 << ((k / 3) % 4)) & 4'hF));
    end

    // 2: clean press row2/col1
    p0 = pulses;
    keys[2][1] = 1'b1;
    wait_valid("t2_valid_seen", 60);
    check_output("t2_code", 32'(key_code), 32'h9);
    check_output("t2_held", 32'(key_held), 32'd1);
    check_output("t2_row", 32'(row_out), 32'hB);
    frozen = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (row_out !== 4'b1011) frozen = 1'b0;
    end
    check_output("t2_row_frozen", 32'(frozen), 32'd1);
    check_output("t2_one_pulse", 32'(pulses - p0), 32'd1);
    keys[2][1] = 1'b0;
    steps(6);
    check_output("t2_held_before_drop", 32'(key_held), 32'd1);
    step();
    check_output("t2_held_dropped", 32'(key_held), 32'd0);
    check_output("t2_resume_row3", 32'(row_out), 32'h7);

    // 3: bouncing press row0/col3, then stable
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      keys[0][3] = ((i / 2) % 2 == 0);
      step();
    end
    check_output("t3_no_pulse_bounce", 32'(pulses - p0), 32'd0);
    keys[0][3] = 1'b1;
    wait_valid("t3_valid_seen", 60);
    check_output("t3_code", 32'(key_code), 32'h3);
    check_output("t3_one_pulse", 32'(pulses - p0), 32'd1);
    keys[0][3] = 1'b0;
    wait_release("t3_release", 30);

    // 4: release bounce on row3/col0
    p0 = pulses;
    keys[3][0] = 1'b1;
    wait_valid("t4_valid_seen", 60);
    check_output("t4_code", 32'(key_code), 32'hC);
    steps(5);
    keys[3][0] = 1'b0;
    steps(2);
    keys[3][0] = 1'b1;
    steps(10);
    check_output("t4_held_through_bounce", 32'(key_held), 32'd1);
    check_output("t4_no_second_pulse", 32'(pulses - p0), 32'd1);
    keys[3][0] = 1'b0;
    steps(6);
    check_output("t4_held_before_drop", 32'(key_held), 32'd1);
    step();
    check_output("t4_held_dropped", 32'(key_held), 32'd0);
    check_output("t4_resume_row0", 32'(row_out), 32'hE);

    // 5: two keys on row1, then a key on another row while held
    p0 = pulses;
    keys[1] = 4'b0101;
    wait_valid("t5_valid_seen", 60);
    check_output("t5_code", 32'(key_code), 32'h4);
    keys[2][0] = 1'b1;
    steps(20);
    check_output("t5_extra_ignored", 32'(pulses - p0), 32'd1);
    check_output("t5_held", 32'(key_held), 32'd1);
    check_output("t5_row", 32'(row_out), 32'hD);
    keys = '0;
    wait_release("t5_release", 30);

    // 6: reset during debounce of row0/col0
    p0 = pulses;
    keys[0][0] = 1'b1;
    begin
      int n = 0;
      while (row_out !== 4'b1110 && n < 30) begin
        step();
        n++;
      end
      check_output("t6_reach_row0", 32'(row_out), 32'hE);
    end
    steps(4);
    rst = 1'b1;
    step();
    check_output("t6_rst_row", 32'(row_out), 32'hE);
    check_output("t6_rst_valid", 32'(key_valid), 32'd0);
    check_output("t6_rst_held", 32'(key_held), 32'd0);
    check_output("t6_rst_code", 32'(key_code), 32'd0);
    check_output("t6_no_pulse_pre_rst", 32'(pulses - p0), 32'd0);
    keys = '0;
    rst = 1'b0;
    steps(10);
    check_output("t6_no_pulse_after", 32'(pulses - p0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
